// File: rtl/ecc_secded_pkg.sv
// ecc_secded_pkg: SECDED codeword helpers and scrubber states shared by the memory
package ecc_secded_pkg;
    localparam int MAX_CW = 72;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_WB} scrub_state_t;
    function automatic int par_w(input int data_w);
        int r = 7;
        for (int p = 7; p >= 1; p--)
            if ((1 << p) >= data_w + p + 1) r = p;
        return r;
    endfunction
    function automatic logic [6:0] secded_syndrome(input logic [MAX_CW-1:0] cw, input int cw_w);
        logic [6:0] s = '0;
        for (int i = 1; i < MAX_CW; i++)
            if (i < cw_w && cw[i]) s = s ^ 7'(i);
        return s;
    endfunction
    function automatic logic [MAX_CW-1:0] secded_encode(input logic [63:0] d, input int data_w);
        logic [MAX_CW-1:0] cw = '0;
        logic [63:0] dd = d;
        logic [6:0] s;
        int cw_w = data_w + par_w(data_w) + 1;
        for (int i = 1; i < MAX_CW; i++)
            if (i < cw_w && (i & (i - 1)) != 0) begin
                cw[i] = dd[0];
                dd = dd >> 1;
            end
        s = secded_syndrome(cw, cw_w);
        for (int k = 0; k < 7; k++)
            if ((1 << k) < cw_w) cw[1 << k] = s[k];
        cw[0] = ^cw;
        return cw;
    endfunction
endpackage

// File: rtl/secded_decoder.sv
// secded_decoder: combinational SECDED codeword to corrected data with sec/ded flags
module secded_decoder import ecc_secded_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int CW_W = 13
) (
    input  logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] data,
    output logic              sec,
    output logic              ded
);
    logic [6:0] syn;
    logic par_bad;
    logic [CW_W-1:0] fixed;
    // flip the bit the syndrome names, then gather data positions LSB-first
    always_comb begin
        syn = secded_syndrome(MAX_CW'(cw), CW_W);
        par_bad = ^cw;
        sec = par_bad && int'(syn) < CW_W;
        ded = par_bad ? !sec : syn != '0;
        fixed = sec ? cw ^ (CW_W'(1) << syn) : cw;
        data = '0;
        for (int i = 1; i < CW_W; i++)
            if ((i & (i - 1)) != 0) data = {fixed[i], data[DATA_W-1:1]};
    end
endmodule

// File: rtl/ecc_secded_scrub_memory.sv
// ecc_secded_scrub_memory: SECDED-protected memory with fault injection and background scrubber
module ecc_secded_scrub_memory import ecc_secded_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH = 1 << ADDR_W,
    parameter int SCRUB_INTERVAL = 256,
    localparam int PAR_W = par_w(DATA_W),
    localparam int CW_W = DATA_W + PAR_W + 1,
    localparam int FA_W = $clog2(CW_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              fault_en,
    input  logic [FA_W-1:0]   fault_addr,
    input  logic              fault2_en,
    input  logic [FA_W-1:0]   fault2_addr,
    input  logic              scrub_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_sec,
    output logic              rd_ded,
    output logic              scrub_busy,
    output logic [15:0]       sec_count,
    output logic [15:0]       ded_count
);
    localparam int IW = $clog2(SCRUB_INTERVAL + 1);
    logic [CW_W-1:0] mem [DEPTH];
    scrub_state_t state;
    logic [ADDR_W-1:0] scrub_addr, next_addr;
    logic [IW-1:0] interval;
    logic [CW_W-1:0] scrub_cw, user_cw, fault_mask;
    logic [DATA_W-1:0] u_data, s_data;
    logic user_v, stale, wb_ok, u_sec, u_ded, s_sec, s_ded;
    logic [1:0] ded_inc;
    assign fault_mask = (fault_en && int'(fault_addr) < CW_W ? CW_W'(1) << fault_addr : '0)
                      | (fault2_en && fault2_addr != fault_addr && int'(fault2_addr) < CW_W ? CW_W'(1) << fault2_addr : '0);
    assign next_addr = scrub_addr == ADDR_W'(DEPTH - 1) ? '0 : scrub_addr + 1'b1;
    assign scrub_busy = state != S_IDLE;
    assign wb_ok = state == S_WB && !wr_en && !stale;
    assign ded_inc = {1'b0, user_v && u_ded} + {1'b0, state == S_CHECK && s_ded};
    secded_decoder #(.DATA_W(DATA_W), .CW_W(CW_W)) u_dec (
        .cw(user_cw ^ fault_mask), .data(u_data), .sec(u_sec), .ded(u_ded));
    secded_decoder #(.DATA_W(DATA_W), .CW_W(CW_W)) s_dec (
        .cw(scrub_cw), .data(s_data), .sec(s_sec), .ded(s_ded));
    // user read pipeline: array read, then faulted decode into the output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            user_v <= 1'b0;
            user_cw <= '0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            rd_sec <= 1'b0;
            rd_ded <= 1'b0;
        end else begin
            user_v <= rd_en && !wr_en;
            if (rd_en) user_cw <= mem[rd_addr];
            rd_valid <= user_v;
            rd_data <= u_data;
            rd_sec <= user_v && u_sec;
            rd_ded <= user_v && u_ded;
        end
    end
    // array writes, scrubber walk with stale-writeback guard, saturating error counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            state <= S_IDLE;
            scrub_addr <= '0;
            interval <= '0;
            scrub_cw <= '0;
            stale <= 1'b0;
            sec_count <= '0;
            ded_count <= '0;
        end else begin
            if (wr_en) mem[wr_addr] <= CW_W'(secded_encode(64'(wr_data), DATA_W));
            else if (wb_ok) mem[scrub_addr] <= CW_W'(secded_encode(64'(s_data), DATA_W));
            if (wb_ok && sec_count != '1) sec_count <= sec_count + 1'b1;
            ded_count <= (17'(ded_count) + 17'(ded_inc) > 17'hFFFF) ? '1 : ded_count + 16'(ded_inc);
            if (state != S_IDLE && wr_en && wr_addr == scrub_addr) stale <= 1'b1;
            case (state)
                S_IDLE: if (scrub_en) begin
                    interval <= interval == IW'(SCRUB_INTERVAL - 1) ? '0 : interval + 1'b1;
                    if (interval == IW'(SCRUB_INTERVAL - 1)) begin
                        state <= S_READ;
                        stale <= 1'b0;
                    end
                end
                S_READ: if (!wr_en && !rd_en) begin
                    scrub_cw <= mem[scrub_addr];
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    state <= s_sec ? S_WB : S_IDLE;
                    if (!s_sec) scrub_addr <= next_addr;
                end
                default: if (!wr_en) begin
                    state <= S_IDLE;
                    scrub_addr <= next_addr;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_secded_scrub_memory.sv
// tb_ecc_secded_scrub_memory: directed checks of read path, fault injection and scrubbing
module tb_ecc_secded_scrub_memory;
    import ecc_secded_pkg::*;
    logic clk = 0, rst = 0, wr_en = 0, rd_en = 0, fault_en = 0, fault2_en = 0, scrub_en = 0;
    logic [3:0] wr_addr = 0, rd_addr = 0, fault_addr = 0, fault2_addr = 0;
    logic [7:0] wr_data = 0, rd_data;
    logic rd_valid, rd_sec, rd_ded, scrub_busy;
    logic [15:0] sec_count, ded_count;
    int n_cmp = 0, n_bad = 0;
    logic early, v, s, e;
    logic [7:0] d;

    ecc_secded_scrub_memory #(.DATA_W(8), .ADDR_W(4), .SCRUB_INTERVAL(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .fault_en(fault_en), .fault_addr(fault_addr),
        .fault2_en(fault2_en), .fault2_addr(fault2_addr), .scrub_en(scrub_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_sec(rd_sec), .rd_ded(rd_ded),
        .scrub_busy(scrub_busy), .sec_count(sec_count), .ded_count(ded_count));

    always #5 clk = ~clk;

    task automatic do_write(input logic [3:0] a, input logic [7:0] dat);
        @(negedge clk); wr_en = 1; wr_addr = a; wr_data = dat;
        @(negedge clk); wr_en = 0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic ev, output logic vv,
                           output logic [7:0] dd, output logic ss, output logic ee);
        @(negedge clk); rd_en = 1; rd_addr = a;
        @(negedge clk); rd_en = 0; ev = rd_valid;
        @(negedge clk); vv = rd_valid; dd = rd_data; ss = rd_sec; ee = rd_ded;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && scrub_busy; i++) @(negedge clk);
        n_cmp++;
        if (scrub_busy !== 1'b0) begin n_bad++; $display("FAIL idle_timeout: scrub_busy=%b want 0", scrub_busy); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_sec, rd_ded, scrub_busy} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {rd_valid, rd_sec, rd_ded, scrub_busy}); end
        n_cmp++;
        if ({sec_count, ded_count} !== 32'h0) begin n_bad++; $display("FAIL reset_counts: got %h want 0", {sec_count, ded_count}); end
    endtask

    task automatic test_write_read();
        do_write(3, 8'hA5);
        n_cmp++;
        if (dut.mem[3] !== 13'h144E) begin n_bad++; $display("FAIL encode_a5: got %h want 144e", dut.mem[3]); end
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({early, v} !== 2'b01) begin n_bad++; $display("FAIL read_latency: got %b want 01", {early, v}); end
        n_cmp++;
        if ({d, s, e} !== {8'hA5, 2'b00}) begin n_bad++; $display("FAIL read_clean: got %h/%b%b want a5/00", d, s, e); end
        @(negedge clk);
        n_cmp++;
        if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse: got %b want 0", rd_valid); end
    endtask

    task automatic test_single_fault();
        fault_en = 1; fault_addr = 5;
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({v, d, s, e} !== {1'b1, 8'hA5, 2'b10}) begin n_bad++; $display("FAIL sec_bit5: got %b %h %b%b want 1 a5 10", v, d, s, e); end
        fault_addr = 0;
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({v, d, s, e} !== {1'b1, 8'hA5, 2'b10}) begin n_bad++; $display("FAIL sec_bit0: got %b %h %b%b want 1 a5 10", v, d, s, e); end
        fault_en = 0;
        n_cmp++;
        if (dut.mem[3] !== 13'h144E) begin n_bad++; $display("FAIL array_untouched: got %h want 144e", dut.mem[3]); end
    endtask

    task automatic test_fault_ignore();
        fault_en = 1; fault_addr = 14;
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({d, s, e} !== {8'hA5, 2'b00}) begin n_bad++; $display("FAIL fault_oob: got %h %b%b want a5 00", d, s, e); end
        fault_addr = 5; fault2_en = 1; fault2_addr = 5;
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({d, s, e} !== {8'hA5, 2'b10}) begin n_bad++; $display("FAIL fault2_same: got %h %b%b want a5 10", d, s, e); end
        fault_en = 0; fault2_en = 0;
    endtask

    task automatic test_double_fault();
        fault_en = 1; fault_addr = 2; fault2_en = 1; fault2_addr = 7;
        do_read(3, early, v, d, s, e);
        n_cmp++;
        if ({v, d, s, e} !== {1'b1, 8'hAD, 2'b01}) begin n_bad++; $display("FAIL ded_read: got %b %h %b%b want 1 ad 01", v, d, s, e); end
        n_cmp++;
        if (ded_count !== 16'd1) begin n_bad++; $display("FAIL ded_count: got %0d want 1", ded_count); end
        fault_en = 0; fault2_en = 0;
    endtask

    task automatic test_back_to_back();
        do_write(5, 8'h5A);
        @(negedge clk); rd_en = 1; rd_addr = 3;
        @(negedge clk); rd_addr = 5;
        @(negedge clk); rd_en = 0;
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL b2b_first: got %b %h want 1 a5", rd_valid, rd_data); end
        @(negedge clk);
        n_cmp++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin n_bad++; $display("FAIL b2b_second: got %b %h want 1 5a", rd_valid, rd_data); end
    endtask

    task automatic test_collision();
        logic seen;
        @(negedge clk); wr_en = 1; rd_en = 1; wr_addr = 5; rd_addr = 5; wr_data = 8'h11;
        @(negedge clk); wr_en = 0; rd_en = 0; seen = rd_valid;
        @(negedge clk); seen = seen | rd_valid;
        @(negedge clk); seen = seen | rd_valid;
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL collide_dropped: rd_valid=%b want 0", seen); end
        do_read(5, early, v, d, s, e);
        n_cmp++;
        if ({v, d} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL collide_write: got %b %h want 1 11", v, d); end
    endtask

    task automatic test_scrub_correct();
        int i;
        @(negedge clk); dut.mem[6] = dut.mem[6] ^ 13'h0010;
        scrub_en = 1;
        for (i = 0; i < 300 && sec_count != 16'd1; i++) @(negedge clk);
        scrub_en = 0;
        n_cmp++;
        if (sec_count !== 16'd1) begin n_bad++; $display("FAIL scrub_sec_count: got %0d want 1", sec_count); end
        wait_idle();
        n_cmp++;
        if (dut.mem[6] !== 13'h0000) begin n_bad++; $display("FAIL scrub_fixed_word: got %h want 0000", dut.mem[6]); end
        do_read(6, early, v, d, s, e);
        n_cmp++;
        if ({v, d, s, e} !== {1'b1, 8'h00, 2'b00}) begin n_bad++; $display("FAIL scrub_reread: got %b %h %b%b want 1 00 00", v, d, s, e); end
    endtask

    task automatic test_scrub_abandon();
        int i;
        @(negedge clk); dut.mem[2] = dut.mem[2] ^ 13'h0200;
        scrub_en = 1;
        for (i = 0; i < 300 && !(dut.state == S_CHECK && dut.scrub_addr == 4'd2); i++) @(negedge clk);
        n_cmp++;
        if (!(dut.state == S_CHECK && dut.scrub_addr == 4'd2)) begin n_bad++; $display("FAIL check_timeout: state=%0d addr=%0d want 2/2", dut.state, dut.scrub_addr); end
        wr_en = 1; wr_addr = 2; wr_data = 8'h3C; scrub_en = 0;
        @(negedge clk); wr_en = 0;
        wait_idle();
        n_cmp++;
        if (sec_count !== 16'd1) begin n_bad++; $display("FAIL abandon_sec_count: got %0d want 1", sec_count); end
        do_read(2, early, v, d, s, e);
        n_cmp++;
        if ({v, d, s, e} !== {1'b1, 8'h3C, 2'b00}) begin n_bad++; $display("FAIL abandon_read: got %b %h %b%b want 1 3c 00", v, d, s, e); end
        n_cmp++;
        if (ded_count !== 16'd1) begin n_bad++; $display("FAIL ded_count_hold: got %0d want 1", ded_count); end
    endtask

    task automatic test_reset_midread();
        logic seen;
        @(negedge clk); rd_en = 1; rd_addr = 3;
        @(negedge clk); rd_en = 0; rst = 0; seen = rd_valid;
        @(negedge clk); rst = 1; seen = seen | rd_valid;
        @(negedge clk); seen = seen | rd_valid;
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_no_valid: rd_valid=%b want 0", seen); end
        n_cmp++;
        if ({sec_count, ded_count} !== 32'h0) begin n_bad++; $display("FAIL reset_counters: got %h want 0", {sec_count, ded_count}); end
        for (int a = 2; a < 7; a++) begin
            do_read(4'(a), early, v, d, s, e);
            n_cmp++;
            if ({v, d, s, e} !== {1'b1, 8'h00, 2'b00}) begin n_bad++; $display("FAIL reset_word%0d: got %b %h %b%b want 1 00 00", a, v, d, s, e); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_single_fault();
        test_fault_ignore();
        test_double_fault();
        test_back_to_back();
        test_collision();
        test_scrub_correct();
        test_scrub_abandon();
        test_reset_midread();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
